secure_debug_regfile: RTL and testbench
=======================================

SECURE_DEBUG_REGFILE -- requirements
Module: secure_debug_regfile

Interface
REQ-001 Parameter DATA_W, default 32: register and debug data width.
REQ-002 Parameter ADDR_W, default 8: debug address width.
REQ-003 Parameter DEPTH, default 256: number of registers, 1..2**ADDR_W.
REQ-004 Parameter KEY_W, default 32: unlock key width.
REQ-005 Parameter MAX_FAILS, default 3: wrong keys allowed before lockout, >=1.
REQ-006 Parameter LOCKOUT_CYCLES, default 1024: lockout duration in clk cycles, >=1.
REQ-007 Parameter IDLE_TIMEOUT, default 4096: idle cycles in UNLOCKED before auto-relock, >=1.
REQ-008 clk  input  1  sole clock; all logic rising-edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 secret_key  input  KEY_W  reference key (fuse-sourced), stable during operation.
REQ-011 unlock_req  input  1  one-cycle unlock attempt strobe.
REQ-012 unlock_key  input  KEY_W  key presented with unlock_req.
REQ-013 relock  input  1  force return to LOCKED.
REQ-014 dbg_req  input  1  access request strobe, one access per asserted cycle.
REQ-015 dbg_we  input  1  1 = write, 0 = read; qualified by dbg_req.
REQ-016 dbg_addr  input  ADDR_W  register index.
REQ-017 dbg_wdata  input  DATA_W  write data.
REQ-018 dbg_ack  output  1  one-cycle completion pulse.
REQ-019 dbg_err  output  1  valid with dbg_ack; access rejected.
REQ-020 dbg_rdata  output  DATA_W  read data, valid with dbg_ack.
REQ-021 unlock_done  output  1  one-cycle pulse ending an evaluated unlock attempt.
REQ-022 unlock_ok  output  1  valid with unlock_done; 1 = key matched.
REQ-023 unlocked  output  1  high only in UNLOCKED.
REQ-024 locked_out  output  1  high only in LOCKOUT.

Function
REQ-025 States: LOCKED, CHECK, UNLOCKED, LOCKOUT; one state register.
REQ-026 LOCKED + unlock_req: capture unlock_key, go to CHECK.
REQ-027 CHECK (one cycle): full-width compare with secret_key; match -> UNLOCKED, fail_cnt=0, unlock_done=1, unlock_ok=1; mismatch -> fail_cnt+1, unlock_done=1, unlock_ok=0.
REQ-028 On mismatch, if incremented fail_cnt equals MAX_FAILS -> LOCKOUT with countdown loaded to LOCKOUT_CYCLES; otherwise -> LOCKED.
REQ-029 LOCKOUT: countdown decrements each cycle; on reaching 0 -> LOCKED and fail_cnt=0; unlock_req ignored, no unlock_done, fail_cnt unchanged.
REQ-030 unlock_req in CHECK or UNLOCKED is ignored; no unlock_done.
REQ-031 UNLOCKED: idle counter resets on each dbg_req and counts otherwise; at IDLE_TIMEOUT consecutive idle cycles -> LOCKED.
REQ-032 relock=1 in UNLOCKED -> LOCKED next cycle; relock has no effect in other states.
REQ-033 Every dbg_req produces dbg_ack exactly one cycle later; back-to-back requests give back-to-back acks.
REQ-034 A request is granted only if state is UNLOCKED, relock is 0, and dbg_addr < DEPTH in the request cycle.
REQ-035 Rejected request: dbg_err=1, dbg_rdata=0, no register modified.
REQ-036 Granted write: reg[dbg_addr] <= dbg_wdata; ack with dbg_err=0, dbg_rdata=0.
REQ-037 Granted read: dbg_rdata = reg[dbg_addr] as of the request cycle; dbg_err=0.
REQ-038 dbg_rdata is 0 whenever dbg_ack is 0; a read never leaks data in a non-granted state.
REQ-039 The fail counter saturates at MAX_FAILS and does not wrap.

Reset
REQ-040 rst=1: state LOCKED; fail_cnt, countdown, and idle counter 0; all registers 0; all outputs 0 on the following cycle.
REQ-041 rst has priority over all inputs; in-flight acks and unlock results are discarded, not emitted.

Verification
REQ-042 After reset, read addr 5 -> ack next cycle, err=1, rdata=0; unlocked=0.
REQ-043 unlock_key=secret_key -> unlock_done+unlock_ok 2 cycles later, unlocked=1; write 0xDEADBEEF to addr 5 then read -> rdata=0xDEADBEEF, err=0.
REQ-044 Three wrong keys -> three unlock_done with ok=0, then locked_out=1 for 1024 cycles; correct key during lockout ignored; afterwards correct key unlocks.
REQ-045 Unlocked, addr >= DEPTH (DEPTH=200, addr 250) -> err=1; relock with simultaneous write to addr 5 -> err=1, addr 5 unchanged.
REQ-046 Unlocked, idle 4096 cycles -> unlocked=0; subsequent read -> err=1; rst mid-lockout -> LOCKED, fail_cnt 0.

Source files
------------

// File: rtl/secure_debug_regfile_if.sv
// secure_debug_regfile_if: debug access bus between a debug host and the secure register file
interface secure_debug_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic              dbg_err;
  logic [DATA_W-1:0] dbg_rdata;
  modport master (output dbg_req, dbg_we, dbg_addr, dbg_wdata, input dbg_ack, dbg_err, dbg_rdata);
  modport slave (input dbg_req, dbg_we, dbg_addr, dbg_wdata, output dbg_ack, dbg_err, dbg_rdata);
endinterface

// File: rtl/secure_debug_regfile.sv
// secure_debug_regfile: key-locked debug register file with brute-force lockout and idle auto-relock
module secure_debug_regfile #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int KEY_W          = 32,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int IDLE_TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_W-1:0]     secret_key,
  input  logic                 unlock_req,
  input  logic [KEY_W-1:0]     unlock_key,
  input  logic                 relock,
  secure_debug_regfile_if.slave dbg,
  output logic                 unlock_done,
  output logic                 unlock_ok,
  output logic                 unlocked,
  output logic                 locked_out
);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {LOCKED, CHECK, UNLOCKED, LOCKOUT} state_t;
  state_t            state;
  logic [FW-1:0]     fail_cnt;
  logic [FW-1:0]     fail_nxt;
  logic [LW-1:0]     lo_cnt;
  logic [IW-1:0]     idle_cnt;
  logic [KEY_W-1:0]  key_q;
  logic              key_match;
  logic              grant;
  logic [DATA_W-1:0] regs [DEPTH];
  assign unlocked   = state == UNLOCKED;
  assign locked_out = state == LOCKOUT;
  assign key_match  = key_q == secret_key;
  assign fail_nxt   = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);
  assign grant      = unlocked && !relock && ({1'b0, dbg.dbg_addr} < (ADDR_W + 1)'(DEPTH));
  // Unlock FSM: key check, fail counting, lockout countdown and idle/forced relock
  always_ff @(posedge clk)
    if (rst) begin
      state       <= LOCKED;
      fail_cnt    <= '0;
      lo_cnt      <= '0;
      idle_cnt    <= '0;
      key_q       <= '0;
      unlock_done <= 1'b0;
      unlock_ok   <= 1'b0;
    end else begin
      unlock_done <= state == CHECK;
      unlock_ok   <= state == CHECK && key_match;
      case (state)
        LOCKED:
          if (unlock_req) begin
            key_q <= unlock_key;
            state <= CHECK;
          end
        CHECK:
          if (key_match) begin
            state    <= UNLOCKED;
            fail_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            fail_cnt <= fail_nxt;
            if (fail_nxt == FW'(MAX_FAILS)) begin
              state  <= LOCKOUT;
              lo_cnt <= LW'(LOCKOUT_CYCLES);
            end else
              state <= LOCKED;
          end
        UNLOCKED:
          if (relock) begin
            state    <= LOCKED;
            idle_cnt <= '0;
          end else if (dbg.dbg_req)
            idle_cnt <= '0;
          else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
            state    <= LOCKED;
            idle_cnt <= '0;
          end else
            idle_cnt <= idle_cnt + IW'(1);
        LOCKOUT:
          if (lo_cnt == LW'(1)) begin
            state    <= LOCKED;
            lo_cnt   <= '0;
            fail_cnt <= '0;
          end else
            lo_cnt <= lo_cnt - LW'(1);
        default: state <= LOCKED;
      endcase
    end
  // Debug access: every request acked next cycle; data only leaves on a granted read
  always_ff @(posedge clk)
    if (rst) begin
      dbg.dbg_ack   <= 1'b0;
      dbg.dbg_err   <= 1'b0;
      dbg.dbg_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      dbg.dbg_ack   <= dbg.dbg_req;
      dbg.dbg_err   <= dbg.dbg_req && !grant;
      dbg.dbg_rdata <= (dbg.dbg_req && grant && !dbg.dbg_we) ? regs[dbg.dbg_addr] : '0;
      if (dbg.dbg_req && grant && dbg.dbg_we) regs[dbg.dbg_addr] <= dbg.dbg_wdata;
    end
endmodule

// File: tb/tb_secure_debug_regfile.sv
// tb_secure_debug_regfile: scoreboard bench for the secure debug register file
module tb_secure_debug_regfile;
  localparam logic [31:0] SECRET = 32'hA5C3_1F0E;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        unlock_req = 1'b0;
  logic [31:0] unlock_key = '0;
  logic        relock = 1'b0;
  logic        unlock_done;
  logic        unlock_ok;
  logic        unlocked;
  logic        locked_out;
  int          n_chk = 0;
  int          n_fail = 0;
  int          lo_cycles = 0;
  logic [32:0] sb [$];
  logic [32:0] sb_e;
  logic        exp_ack;
  logic [31:0] mem [256];
  secure_debug_regfile_if #(.DATA_W(32), .ADDR_W(8)) dbg ();
  secure_debug_regfile #(.DEPTH(200)) dut (
    .clk(clk), .rst(rst), .secret_key(SECRET), .unlock_req(unlock_req), .unlock_key(unlock_key),
    .relock(relock), .dbg(dbg), .unlock_done(unlock_done), .unlock_ok(unlock_ok),
    .unlocked(unlocked), .locked_out(locked_out)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic monitor();
    forever begin
      @(posedge clk);
      exp_ack = dbg.dbg_req & !rst;
      @(negedge clk);
      if (locked_out) lo_cycles++;
      n_chk++;
      if (dbg.dbg_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL ack_timing: ack=%b required %b at %0t", dbg.dbg_ack, exp_ack, $time);
      end
      if (dbg.dbg_ack === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: ack with empty scoreboard at %0t", $time);
        end else begin
          sb_e = sb.pop_front();
          if ({dbg.dbg_err, dbg.dbg_rdata} !== sb_e) begin
            n_fail++;
            $display("FAIL ack_data: err=%b rdata=%h required err=%b rdata=%h at %0t",
                     dbg.dbg_err, dbg.dbg_rdata, sb_e[32], sb_e[31:0], $time);
          end
        end
      end else begin
        n_chk++;
        if ({dbg.dbg_err, dbg.dbg_rdata} !== 33'h0) begin
          n_fail++;
          $display("FAIL idle_leak: err=%b rdata=%h required 0 with no ack at %0t", dbg.dbg_err, dbg.dbg_rdata, $time);
        end
      end
    end
  endtask
  task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wd, input logic grant,
                        input logic rl = 1'b0);
    dbg.dbg_req = 1'b1;
    dbg.dbg_we = we;
    dbg.dbg_addr = addr;
    dbg.dbg_wdata = wd;
    relock = rl;
    if (!rst) sb.push_back(grant ? {1'b0, we ? 32'h0 : mem[addr]} : {1'b1, 32'h0});
    if (!rst && grant && we) mem[addr] = wd;
    @(posedge clk); #1;
    dbg.dbg_req = 1'b0;
    relock = 1'b0;
  endtask
  task automatic try_key(input logic [31:0] k, input logic exp_done, input logic exp_ok, input string nm);
    unlock_req = 1'b1;
    unlock_key = k;
    @(posedge clk); #1;
    unlock_req = 1'b0;
    n_chk++;
    if (unlock_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: unlock_done=%b required 0", nm, unlock_done);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({unlock_done, unlock_ok} !== {exp_done, exp_ok}) begin
      n_fail++;
      $display("FAIL %s: done=%b ok=%b required done=%b ok=%b", nm, unlock_done, unlock_ok, exp_done, exp_ok);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask
  task automatic test_reset();
    n_chk++;
    if ({unlocked, locked_out, unlock_done, unlock_ok, dbg.dbg_ack, dbg.dbg_err, dbg.dbg_rdata} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: unl=%b lo=%b done=%b ok=%b ack=%b err=%b rdata=%h required all 0",
               unlocked, locked_out, unlock_done, unlock_ok, dbg.dbg_ack, dbg.dbg_err, dbg.dbg_rdata);
    end
    access(1'b0, 8'd5, 32'h0, 1'b0);
    n_chk++;
    if (unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_unlocked: unlocked=%b required 0", unlocked);
    end
    rst = 1'b1;
    unlock_req = 1'b1;
    unlock_key = SECRET;
    access(1'b0, 8'd5, 32'h0, 1'b0);
    unlock_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({unlock_done, unlocked} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_priority: done=%b unlocked=%b required 0 0", unlock_done, unlocked);
    end
    unlock_req = 1'b1;
    unlock_key = SECRET;
    @(posedge clk); #1;
    unlock_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({unlock_done, unlock_ok, unlocked} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_discard_check: done=%b ok=%b unlocked=%b required 0 0 0", unlock_done, unlock_ok, unlocked);
    end
  endtask
  task automatic test_unlock_rw();
    try_key(SECRET, 1'b1, 1'b1, "unlock_good");
    n_chk++;
    if (unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock_state: unlocked=%b required 1", unlocked);
    end
    access(1'b1, 8'd5, 32'hDEAD_BEEF, 1'b1);
    access(1'b0, 8'd5, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) access(1'b1, 8'(i * 3), 32'h1111_0000 + 32'(i * 7), 1'b1);
    for (int i = 0; i < 4; i++) access(1'b0, 8'(i * 3), 32'h0, 1'b1);
    access(1'b1, 8'd199, 32'hCAFE_0199, 1'b1);
    access(1'b0, 8'd199, 32'h0, 1'b1);
    unlock_req = 1'b1;
    unlock_key = 32'h0;
    @(posedge clk); #1;
    unlock_req = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({unlock_done, unlocked} !== 2'b01) begin
      n_fail++;
      $display("FAIL unlock_ignored: done=%b unlocked=%b required 0 1", unlock_done, unlocked);
    end
  endtask
  task automatic test_bounds();
    access(1'b1, 8'd250, 32'h1234_5678, 1'b0);
    access(1'b0, 8'd250, 32'h0, 1'b0);
    access(1'b1, 8'd200, 32'h1234_5678, 1'b0);
    access(1'b0, 8'd200, 32'h0, 1'b0);
    access(1'b0, 8'd199, 32'h0, 1'b1);
    access(1'b1, 8'd5, 32'h0BAD_F00D, 1'b0, 1'b1);
    n_chk++;
    if (unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_state: unlocked=%b required 0", unlocked);
    end
    try_key(SECRET, 1'b1, 1'b1, "unlock_after_relock");
    access(1'b0, 8'd5, 32'h0, 1'b1);
  endtask
  task automatic test_lockout();
    relock = 1'b1;
    @(posedge clk); #1;
    relock = 1'b0;
    try_key(SECRET ^ 32'h8000_0000, 1'b1, 1'b0, "bad_key1");
    try_key(SECRET ^ 32'h0000_0001, 1'b1, 1'b0, "bad_key2");
    n_chk++;
    if (locked_out !== 1'b0) begin
      n_fail++;
      $display("FAIL early_lockout: locked_out=%b required 0", locked_out);
    end
    lo_cycles = 0;
    try_key(32'h0, 1'b1, 1'b0, "bad_key3");
    n_chk++;
    if ({locked_out, unlocked} !== 2'b10) begin
      n_fail++;
      $display("FAIL lockout_entry: locked_out=%b unlocked=%b required 1 0", locked_out, unlocked);
    end
    try_key(SECRET, 1'b0, 1'b0, "key_in_lockout");
    access(1'b0, 8'd5, 32'h0, 1'b0);
    for (int i = 0; i < 1100 && locked_out; i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (locked_out !== 1'b0 || lo_cycles != 1024) begin
      n_fail++;
      $display("FAIL lockout_length: locked_out=%b cycles=%0d required 0 and 1024", locked_out, lo_cycles);
    end
    try_key(SECRET, 1'b1, 1'b1, "unlock_after_lockout");
    relock = 1'b1;
    @(posedge clk); #1;
    relock = 1'b0;
    try_key(SECRET ^ 32'h0001_0000, 1'b1, 1'b0, "bad_key4");
    try_key(SECRET ^ 32'h0001_0000, 1'b1, 1'b0, "bad_key5");
    try_key(SECRET ^ 32'h0001_0000, 1'b1, 1'b0, "bad_key6");
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    n_chk++;
    if ({locked_out, unlocked} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_in_lockout: locked_out=%b unlocked=%b required 0 0", locked_out, unlocked);
    end
    try_key(SECRET ^ 32'h4000_0000, 1'b1, 1'b0, "bad_key7");
    try_key(SECRET ^ 32'h4000_0000, 1'b1, 1'b0, "bad_key8");
    n_chk++;
    if (locked_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_cnt_cleared: locked_out=%b required 0", locked_out);
    end
    try_key(SECRET, 1'b1, 1'b1, "unlock_after_reset");
    access(1'b0, 8'd5, 32'h0, 1'b1);
  endtask
  task automatic test_idle();
    access(1'b1, 8'd7, 32'h0000_0077, 1'b1);
    repeat (4095) @(posedge clk);
    #1;
    n_chk++;
    if (unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_early: unlocked=%b required 1 after 4095 idle cycles", unlocked);
    end
    @(posedge clk); #1;
    n_chk++;
    if (unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_relock: unlocked=%b required 0 after 4096 idle cycles", unlocked);
    end
    access(1'b0, 8'd7, 32'h0, 1'b0);
  endtask
  initial begin
    dbg.dbg_req = 1'b0;
    dbg.dbg_we = 1'b0;
    dbg.dbg_addr = '0;
    dbg.dbg_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_unlock_rw();
    test_bounds();
    test_lockout();
    test_idle();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d responses outstanding required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
